vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, write-posting FIFO depth; power of two, minimum 2.
REQ-002 Parameter H_PIX, default 640, visible columns; V_PIX, default 480, visible rows.
REQ-003 vga_clk  in  1  sole clock, 25 MHz pixel clock.
REQ-004 clr  in  1  reset; synchronous to vga_clk, active-high.
REQ-005 vga_rdn  in  1  display read request, active-low.
REQ-006 vga_row  in  9  display read row.
REQ-007 vga_col  in  10  display read column.
REQ-008 vga_data  out  12  pixel returned to display, bbbb_gggg_rrrr.
REQ-009 wr_req  in  1  writer request; wr_row 9, wr_col 10, wr_data 12 inputs qualify it.
REQ-010 wr_ack  out  1  writer accept; a transfer occurs when wr_req && wr_ack are both high on a rising edge.
REQ-011 fill_start  in  1  one-cycle pulse that starts a clear-screen operation; fill_color in 12 is the colour.
REQ-012 fill_busy  out  1  fill in progress; fill_done out 1 is a one-cycle completion pulse.
REQ-013 wr_err  out  1  sticky flag for an out-of-range write.
REQ-014 mem_en, mem_we out 1; mem_addr out 19 = {row[8:0], col[9:0]}; mem_wdata out 12; mem_rdata in 12. Pixel RAM is synchronous with one-cycle read latency.

Function
REQ-015 Display reads have absolute priority: when vga_rdn=0, mem_en=1, mem_we=0 and mem_addr={vga_row,vga_col} combinationally in the same cycle.
REQ-016 vga_data SHALL equal mem_rdata, so display data is valid one cycle after vga_rdn=0, with zero added latency.
REQ-017 wr_ack = !fifo_full && !clr && !fill_start_pending; a writer stall costs no data.
REQ-018 Accepted writes with wr_row >= V_PIX or wr_col >= H_PIX SHALL be acked, dropped (not enqueued) and SHALL set wr_err.
REQ-019 Write slot: any cycle with vga_rdn=1. The FIFO head is written first (mem_en=1, mem_we=1, head address/data) and popped on the same edge.
REQ-020 If a slot occurs with the FIFO empty and fill_busy=1, the fill engine writes fill_color at its current counter position, then advances the counter.
REQ-021 Fill counter: column increments 0..H_PIX-1, wraps to 0 and increments the row; after row V_PIX-1, column H_PIX-1 is written, fill_busy drops and fill_done pulses on the next cycle.
REQ-022 Fill FSM states: IDLE -> RUN on fill_start; RUN -> DONE after the last pixel is written; DONE -> IDLE unconditionally after 1 cycle. fill_start is ignored in RUN and DONE.
REQ-023 Simultaneous enqueue and pop on a full FIFO is legal, and occupancy stays unchanged. wr_ack follows pre-edge fullness.
REQ-024 Pixels written by the FIFO during a fill are overwritten by the fill only if the fill counter has not yet passed them; ordering is not otherwise guaranteed.
REQ-025 When no slot and no pending work exist, mem_en=0, mem_we=0 and mem_addr/mem_wdata hold their last value.

Reset
REQ-026 While clr=1: FIFO emptied, fill FSM in IDLE, fill counters 0, fill_busy=0, fill_done=0, wr_err=0, wr_ack=0, mem_we=0. Display reads still pass through.
REQ-027 clr asserted mid-fill aborts the fill with no fill_done pulse. clr asserted with queued writes discards them.

Configuration
REQ-028 Macro VRAM_ARB_VBLANK_EN: when defined, adds input vga_vblank (1 bit, active-high), and FIFO and fill writes are issued only when vga_rdn=1 && vga_vblank=1, which prevents tearing. When undefined, the port is absent and every vga_rdn=1 cycle is a write slot.

Structure
REQ-029 Shared package vram_pkg SHALL hold pixel_t (12 bits), row_t (9), col_t (10), constants H_PIX_DEF=640 and V_PIX_DEF=480, and the fill FSM state enum.
REQ-030 The FIFO SHALL be sub-module vram_wr_fifo (synchronous, first-word-fall-through, FIFO_DEPTH entries of {row,col,data}, full/empty flags).

Verification
REQ-031 vga_rdn=0, row 10, col 20, RAM preloaded 12'hABC -> mem_addr={9'd10,10'd20}, mem_we=0, vga_data=12'hABC next cycle.
REQ-032 4 writes back-to-back with vga_rdn held 0 -> wr_ack falls after the 4th; release vga_rdn=1 -> 4 consecutive mem_we pulses in FIFO order, then wr_ack=1.
REQ-033 Write row 480, col 0 -> acked, no mem_we, wr_err=1 until clr.
REQ-034 fill_start with fill_color 12'h00F, vga_rdn=1 always -> exactly 307200 writes, last address {9'd479,10'd639}, fill_done pulses once.
REQ-035 clr pulsed at write 1000 of a fill -> fill_busy=0, no fill_done, FIFO empty; next fill_start restarts at address 0.
REQ-036 With VRAM_ARB_VBLANK_EN defined and vga_vblank=0, vga_rdn=1, FIFO non-empty -> no mem_we; raise vblank -> drain starts on the same cycle.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared pixel/coordinate types, default resolution and fill FSM states
// used by the VRAM arbiter and its write-posting FIFO.
package vram_pkg;

  typedef logic [11:0] pixel_t;
  typedef logic [8:0]  row_t;
  typedef logic [9:0]  col_t;

  localparam int unsigned H_PIX_DEF = 640;
  localparam int unsigned V_PIX_DEF = 480;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_t;

  typedef struct packed {
    row_t   row;
    col_t   col;
    pixel_t data;
  } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous first-word-fall-through FIFO of posted pixel writes;
// FIFO_DEPTH must be a power of two (pointers wrap naturally).
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_clr,
  input  logic      i_push,
  input  wr_entry_t i_data,
  input  logic      i_pop,
  output wr_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  wr_entry_t     r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && !o_empty;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port pixel RAM arbiter; display reads always win, posted writes and
// a clear-screen fill use the idle slots. Macro VRAM_ARB_VBLANK_EN adds vga_vblank slot gating.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_PIX      = H_PIX_DEF,
  parameter int unsigned V_PIX      = V_PIX_DEF
) (
  input  logic        vga_clk,
  input  logic        clr,
  input  logic        vga_rdn,
  input  logic [8:0]  vga_row,
  input  logic [9:0]  vga_col,
  output logic [11:0] vga_data,
`ifdef VRAM_ARB_VBLANK_EN
  input  logic        vga_vblank,
`endif
  input  logic        wr_req,
  input  logic [8:0]  wr_row,
  input  logic [9:0]  wr_col,
  input  logic [11:0] wr_data,
  output logic        wr_ack,
  input  logic        fill_start,
  input  logic [11:0] fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        wr_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata
);

  localparam row_t ROW_LAST = row_t'(V_PIX - 1);
  localparam col_t COL_LAST = col_t'(H_PIX - 1);

  fill_state_t r_state;
  fill_state_t w_state_nxt;
  row_t        r_fill_row;
  col_t        r_fill_col;
  pixel_t      r_fill_color;
  logic        r_wr_err;
  logic [18:0] r_last_addr;
  pixel_t      r_last_wdata;

  wr_entry_t   w_fifo_in;
  wr_entry_t   w_fifo_head;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_slot;
  logic        w_fifo_wr;
  logic        w_fill_wr;
  logic        w_fill_last;
  logic        w_start;
  logic        w_in_range;
  logic        w_accept;

`ifdef VRAM_ARB_VBLANK_EN
  assign w_slot = vga_rdn && vga_vblank;
`else
  assign w_slot = vga_rdn;
`endif

  assign w_start     = fill_start && (r_state == FILL_IDLE);
  assign wr_ack      = !w_fifo_full && !clr && !w_start;
  assign w_accept    = wr_req && wr_ack;
  assign w_in_range  = (32'(wr_row) < V_PIX) && (32'(wr_col) < H_PIX);
  assign w_fifo_in   = {wr_row, wr_col, wr_data};

  // Queued writes take the slot ahead of the fill engine.
  assign w_fifo_wr   = w_slot && !clr && !w_fifo_empty;
  assign w_fill_wr   = w_slot && !clr && w_fifo_empty && (r_state == FILL_RUN);
  assign w_fill_last = (r_fill_row == ROW_LAST) && (r_fill_col == COL_LAST);

  vram_wr_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_wr_fifo (
    .i_clk  (vga_clk),
    .i_clr  (clr),
    .i_push (w_accept && w_in_range),
    .i_data (w_fifo_in),
    .i_pop  (w_fifo_wr),
    .o_head (w_fifo_head),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

  always_ff @(posedge vga_clk) begin
    if (clr) begin
      r_state <= FILL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL_IDLE: if (fill_start) w_state_nxt = FILL_RUN;
      FILL_RUN:  if (w_fill_wr && w_fill_last) w_state_nxt = FILL_DONE;
      FILL_DONE: w_state_nxt = FILL_IDLE;
      default:   w_state_nxt = FILL_IDLE;
    endcase
  end

  always_comb begin
    fill_busy = !clr && (r_state == FILL_RUN);
    fill_done = !clr && (r_state == FILL_DONE);
  end

  always_ff @(posedge vga_clk) begin
    if (clr || w_start) begin
      r_fill_row <= '0;
      r_fill_col <= '0;
    end else if (w_fill_wr) begin
      if (r_fill_col == COL_LAST) begin
        r_fill_col <= '0;
        r_fill_row <= (r_fill_row == ROW_LAST) ? '0 : r_fill_row + 1'b1;
      end else begin
        r_fill_col <= r_fill_col + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (w_start) begin
      r_fill_color <= fill_color;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (clr) begin
      r_wr_err <= 1'b0;
    end else if (w_accept && !w_in_range) begin
      r_wr_err <= 1'b1;
    end
  end

  assign wr_err = r_wr_err && !clr;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_last_addr;
    mem_wdata = r_last_wdata;
    if (!vga_rdn) begin
      mem_en   = 1'b1;
      mem_addr = {vga_row, vga_col};
    end else if (w_fifo_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {w_fifo_head.row, w_fifo_head.col};
      mem_wdata = w_fifo_head.data;
    end else if (w_fill_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {r_fill_row, r_fill_col};
      mem_wdata = r_fill_color;
    end
  end

  always_ff @(posedge vga_clk) begin
    r_last_addr  <= mem_addr;
    r_last_wdata <= clr ? '0 : mem_wdata;
  end

  assign vga_data = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench with a queue/index reference model of the arbiter,
// a RAM model behind the memory port, and literal checks on the key scenarios.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HP    = 20;
  localparam int unsigned VP    = 6;
  localparam logic [18:0] PRE_A = {9'd10, 10'd20};

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        clr, vga_rdn, wr_req, wr_ack, fill_start, fill_busy, fill_done, wr_err;
  logic        mem_en, mem_we;
  logic [8:0]  vga_row, wr_row;
  logic [9:0]  vga_col, wr_col;
  logic [11:0] vga_data, wr_data, fill_color, mem_wdata;
  logic [11:0] mem_rdata = '0;
  logic [18:0] mem_addr;
`ifdef VRAM_ARB_VBLANK_EN
  logic        vga_vblank;
`endif

  vram_arbiter #(
    .FIFO_DEPTH(DEPTH),
    .H_PIX     (HP),
    .V_PIX     (VP)
  ) dut (
    .vga_clk   (clk),
    .clr       (clr),
    .vga_rdn   (vga_rdn),
    .vga_row   (vga_row),
    .vga_col   (vga_col),
    .vga_data  (vga_data),
`ifdef VRAM_ARB_VBLANK_EN
    .vga_vblank(vga_vblank),
`endif
    .wr_req    (wr_req),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .fill_start(fill_start),
    .fill_color(fill_color),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .wr_err    (wr_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_we = 0;
  int          n_done = 0;
  logic [18:0] last_we_addr = '0;
  bit          chk_en = 1'b0;
  bit          pre_ld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // RAM behind the memory port: one-cycle read latency.
  logic [11:0] env_ram [0:524287];
  always @(posedge clk) begin
    if (pre_ld) env_ram[PRE_A] <= 12'hABC;
    if (mem_en) begin
      if (mem_we) env_ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= env_ram[mem_addr];
    end
  end

  // Reference model state.
  typedef struct packed {
    logic [8:0]  row;
    logic [9:0]  col;
    logic [11:0] data;
  } ent_t;

  logic [11:0] mdl_ram [0:524287];
  ent_t        q[$];
  bit          m_fill = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  int          m_idx = 0;
  logic [11:0] m_color = '0;
  logic [18:0] m_last_addr = '0;
  logic [11:0] m_last_wdata = '0;
  logic [11:0] m_vga = '0;
  bit          m_vga_vld = 1'b0;

  bit          e_slot, e_idle, e_ack, e_en, e_we, e_pop, e_fillwr;
  logic [18:0] e_addr = '0;
  logic [11:0] e_wdata = '0;

  // Compare process: expected outputs from the model state and current inputs.
  always @(negedge clk) begin
`ifdef VRAM_ARB_VBLANK_EN
    e_slot = vga_rdn && vga_vblank;
`else
    e_slot = vga_rdn;
`endif
    e_idle   = !m_fill && !m_done;
    e_ack    = !clr && (q.size() < DEPTH) && !(fill_start && e_idle);
    e_en     = 1'b0;
    e_we     = 1'b0;
    e_pop    = 1'b0;
    e_fillwr = 1'b0;
    e_addr   = m_last_addr;
    e_wdata  = m_last_wdata;
    if (!vga_rdn) begin
      e_en   = 1'b1;
      e_addr = {vga_row, vga_col};
    end else if (e_slot && !clr && q.size() > 0) begin
      e_en = 1'b1; e_we = 1'b1; e_pop = 1'b1;
      e_addr  = {q[0].row, q[0].col};
      e_wdata = q[0].data;
    end else if (e_slot && !clr && m_fill) begin
      e_en = 1'b1; e_we = 1'b1; e_fillwr = 1'b1;
      e_addr  = {9'(m_idx / HP), 10'(m_idx % HP)};
      e_wdata = m_color;
    end
    if (chk_en) begin
      chk("wr_ack", 32'(wr_ack), 32'(e_ack));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("fill_busy", 32'(fill_busy), 32'(m_fill && !clr));
      chk("fill_done", 32'(fill_done), 32'(m_done && !clr));
      chk("wr_err", 32'(wr_err), 32'(m_err && !clr));
      if (m_vga_vld) chk("vga_data", 32'(vga_data), 32'(m_vga));
    end
    if (mem_en && mem_we) begin
      n_we++;
      last_we_addr = mem_addr;
    end
    if (fill_done) n_done++;
  end

  // Model update on the active edge.
  always @(posedge clk) begin
    if (pre_ld) mdl_ram[PRE_A] = 12'hABC;
    m_vga_vld = e_en && !e_we;
    if (m_vga_vld) m_vga = mdl_ram[e_addr];
    if (e_we) mdl_ram[e_addr] = e_wdata;
    m_last_addr  = e_addr;
    m_last_wdata = clr ? 12'h000 : e_wdata;
    if (clr) begin
      q.delete();
      m_fill = 1'b0; m_done = 1'b0; m_err = 1'b0; m_idx = 0;
    end else begin
      m_done = 1'b0;
      if (e_pop) void'(q.pop_front());
      if (e_fillwr) begin
        m_idx++;
        if (m_idx == int'(HP * VP)) begin
          m_fill = 1'b0; m_done = 1'b1; m_idx = 0;
        end
      end
      if (fill_start && e_idle) begin
        m_fill = 1'b1; m_idx = 0; m_color = fill_color;
      end
      if (wr_req && e_ack) begin
        if (32'(wr_row) >= VP || 32'(wr_col) >= HP) m_err = 1'b1;
        else q.push_back('{row: wr_row, col: wr_col, data: wr_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 1000 && n_done == 0; c++) tick();
    if (n_done == 0) chk({name, "_timeout"}, 32'(n_done), 32'd1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; vga_rdn = 1'b1; vga_row = '0; vga_col = '0;
    wr_req = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    fill_start = 1'b0; fill_color = '0; pre_ld = 1'b1;
`ifdef VRAM_ARB_VBLANK_EN
    vga_vblank = 1'b1;
`endif
    tick();
    pre_ld = 1'b0;
    tick();
    chk("rst_ack", 32'(wr_ack), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk_en = 1'b1;
    clr = 1'b0;
    tick();

    // Display read of a preloaded pixel.
    vga_rdn = 1'b0; vga_row = 9'd10; vga_col = 10'd20;
    settle();
    chk("rd_addr", 32'(mem_addr), 32'h2814);
    chk("rd_we", 32'(mem_we), 32'd0);
    tick();
    chk("rd_data", 32'(vga_data), 32'hABC);

    // Fill the FIFO while reads hold the port, then drain it.
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_row = 9'(i + 1); wr_col = 10'(2 * i); wr_data = 12'(12'h100 + i);
      settle();
      chk("q_ack", 32'(wr_ack), 32'd1);
      tick();
    end
    wr_row = 9'd5; wr_col = 10'd8; wr_data = 12'h1FF;
    settle();
    chk("q_full_ack", 32'(wr_ack), 32'd0);
    tick();
    wr_req = 1'b0; vga_rdn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_we", 32'(mem_we), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'((i + 1) * 1024 + 2 * i));
      chk("drain_data", 32'(mem_wdata), 32'(12'h100 + i));
      tick();
    end
    chk("drain_ack", 32'(wr_ack), 32'd1);
    chk("drain_idle_we", 32'(mem_we), 32'd0);
    tick();

    // Out-of-range write: acked, dropped, sticky error.
    wr_req = 1'b1; wr_row = 9'd480; wr_col = 10'd0; wr_data = 12'hBAD;
    settle();
    chk("oor_ack", 32'(wr_ack), 32'd1);
    tick();
    wr_req = 1'b0;
    settle();
    chk("oor_err", 32'(wr_err), 32'd1);
    chk("oor_we", 32'(mem_we), 32'd0);
    tick(); tick();
    chk("oor_sticky", 32'(wr_err), 32'd1);

    // Full clear-screen fill with the port always free.
    n_we = 0; n_done = 0;
    fill_start = 1'b1; fill_color = 12'h00F;
    tick();
    fill_start = 1'b0;
    wait_done("fill1");
    chk("fill_writes", 32'(n_we), 32'(HP * VP));
    chk("fill_last", 32'(last_we_addr), 32'h1413);
    chk("fill_done_cnt", 32'(n_done), 32'd1);
    vga_rdn = 1'b0; vga_row = 9'd3; vga_col = 10'd7;
    tick();
    chk("fill_pix", 32'(vga_data), 32'h00F);
    vga_rdn = 1'b1;

    // Fill interleaved with reads, posted writes and an ignored restart.
    n_done = 0;
    fill_start = 1'b1; fill_color = 12'h0F0;
    tick();
    fill_start = 1'b0;
    repeat (10) tick();
    wr_req = 1'b1; wr_row = 9'd0; wr_col = 10'd1; wr_data = 12'h123;
    tick();
    wr_row = 9'd5; wr_col = 10'd10; wr_data = 12'h456;
    tick();
    wr_req = 1'b0; fill_start = 1'b1; fill_color = 12'hF00;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vga_rdn = i[0];
      vga_row = 9'(i); vga_col = 10'(i);
      tick();
    end
    vga_rdn = 1'b1;
    wait_done("fill2");
    chk("fill2_done_cnt", 32'(n_done), 32'd1);
    vga_rdn = 1'b0; vga_row = 9'd0; vga_col = 10'd1;
    tick();
    chk("passed_pix", 32'(vga_data), 32'h123);
    vga_row = 9'd5; vga_col = 10'd10;
    tick();
    chk("overwritten_pix", 32'(vga_data), 32'h0F0);

    // Full FIFO: a request during the draining edge is refused, then accepted.
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_row = 9'd2; wr_col = 10'(i); wr_data = 12'(12'h200 + i);
      tick();
    end
    vga_rdn = 1'b1; wr_col = 10'd9; wr_data = 12'h2AA;
    settle();
    chk("full_pop_ack", 32'(wr_ack), 32'd0);
    tick();
    chk("after_pop_ack", 32'(wr_ack), 32'd1);
    tick();
    wr_req = 1'b0;
    repeat (6) tick();

    // Clear mid-fill aborts it and discards queued writes.
    n_we = 0; n_done = 0;
    fill_start = 1'b1; fill_color = 12'h555;
    tick();
    fill_start = 1'b0;
    for (int c = 0; c < 200 && n_we < 50; c++) tick();
    vga_rdn = 1'b0; wr_req = 1'b1; wr_row = 9'd2; wr_col = 10'd3; wr_data = 12'h777;
    tick();
    wr_req = 1'b0; clr = 1'b1;
    settle();
    chk("clr_busy", 32'(fill_busy), 32'd0);
    chk("clr_ack", 32'(wr_ack), 32'd0);
    tick();
    clr = 1'b0; vga_rdn = 1'b1;
    settle();
    chk("clr_noq_we", 32'(mem_we), 32'd0);
    repeat (3) tick();
    chk("clr_no_done", 32'(n_done), 32'd0);
    chk("clr_err", 32'(wr_err), 32'd0);
    fill_start = 1'b1; fill_color = 12'h0AA;
    tick();
    fill_start = 1'b0;
    settle();
    chk("restart_we", 32'(mem_we), 32'd1);
    chk("restart_addr", 32'(mem_addr), 32'd0);
    wait_done("fill3");

`ifdef VRAM_ARB_VBLANK_EN
    // Writes wait for vertical blanking.
    vga_vblank = 1'b0; vga_rdn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_req = 1'b1; wr_row = 9'd1; wr_col = 10'(i); wr_data = 12'(12'h300 + i);
      tick();
    end
    wr_req = 1'b0;
    settle();
    chk("vb_hold_we", 32'(mem_we), 32'd0);
    tick();
    chk("vb_hold_we2", 32'(mem_we), 32'd0);
    vga_vblank = 1'b1;
    settle();
    chk("vb_drain_we", 32'(mem_we), 32'd1);
    chk("vb_drain_addr", 32'(mem_addr), 32'h400);
    repeat (3) tick();
`endif

    repeat (2) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
